// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//   EX->MEM pipeline register with valid/ready handshake, synchronous flush
//   and an optional 2-entry skid buffer (registered in_ready).
// Parameters
//   DATA_W     width of alu_out / write_data
//   REG_ADDR_W width of destination register index
//   SKID       1 = 2-entry skid buffer, registered in_ready
//              0 = single entry, combinational in_ready
// Ports
//   clock, reset_n           rising-edge clock, async active-low reset
//   flush                    sync kill of held entries and current input
//   in_valid / in_ready      EX-side handshake
//   in_*                     EX controls, ALU result, store data, dest reg
//   out_valid / out_ready    MEM-side handshake
//   out_*                    registered head-of-stage fields
//   occupancy                entries held (0..2)
module ex_mem_pipe_reg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned SKID       = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic                  in_mem_to_reg,
   input  logic                  in_mem_write,
   input  logic                  in_zero,
   input  logic [DATA_W-1:0]     in_alu_out,
   input  logic [DATA_W-1:0]     in_write_data,
   input  logic [REG_ADDR_W-1:0] in_write_reg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_reg_write,
   output logic                  out_mem_to_reg,
   output logic                  out_mem_write,
   output logic                  out_zero,
   output logic [DATA_W-1:0]     out_alu_out,
   output logic [DATA_W-1:0]     out_write_data,
   output logic [REG_ADDR_W-1:0] out_write_reg,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int unsigned PW = 2 * DATA_W + REG_ADDR_W;

   state_t          state_q, state_d;
   logic [3:0]      in_ctrl, main_ctrl, skid_ctrl;
   logic [PW-1:0]   in_data, main_data, skid_data;
   logic            in_xfer, out_xfer;
   logic            load_main_in, load_main_skid, load_skid;

   // ctrl order: {reg_write, mem_to_reg, mem_write, zero}
   assign in_ctrl  = {in_reg_write, in_mem_to_reg, in_mem_write, in_zero};
   assign in_data  = {in_alu_out, in_write_data, in_write_reg};

   assign out_valid = (state_q != EMPTY);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Write-enables are gated by valid so a bubble can never commit.
   assign out_reg_write  = main_ctrl[3] & out_valid;
   assign out_mem_to_reg = main_ctrl[2];
   assign out_mem_write  = main_ctrl[1] & out_valid;
   assign out_zero       = main_ctrl[0];
   assign {out_alu_out, out_write_data, out_write_reg} = main_data;
   assign occupancy = state_q;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  state_d      = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               case ({in_xfer, out_xfer})
                  2'b10: begin
                     state_d   = FULL;
                     load_skid = 1'b1;
                  end
                  2'b01: state_d = EMPTY;
                  2'b11: load_main_in = 1'b1;
                  default: state_d = ONE;
               endcase
            end
            FULL: begin
               if (out_xfer) begin
                  state_d        = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush clears only the control bits; data fields may hold stale values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
      end else if (load_main_in) begin
         main_ctrl <= in_ctrl;
         main_data <= in_data;
      end else if (load_main_skid) begin
         main_ctrl <= skid_ctrl;
         main_data <= skid_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (load_skid) begin
         skid_ctrl <= in_ctrl;
         skid_data <= in_data;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         // Registered ready: look ahead at next state so the upstream
         // stall path starts at a flop.
         logic ready_q;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (state_d != FULL);
            end
         end
         assign in_ready = ready_q;
      end else begin : g_noskid
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   // DUT A: SKID=1, 32-bit
   logic        a_flush, a_iv, a_ir, a_rw, a_m2r, a_mw, a_zero, a_ov, a_ordy;
   logic        a_orw, a_om2r, a_omw, a_ozero;
   logic [31:0] a_alu, a_wd, a_oalu, a_owd;
   logic [4:0]  a_wreg, a_owreg;
   logic [1:0]  a_occ;

   // DUT B: SKID=0, 64-bit
   logic        b_flush, b_iv, b_ir, b_rw, b_m2r, b_mw, b_zero, b_ov, b_ordy;
   logic        b_orw, b_om2r, b_omw, b_ozero;
   logic [63:0] b_alu, b_wd, b_oalu, b_owd;
   logic [4:0]  b_wreg, b_owreg;
   logic [1:0]  b_occ;

   int n_cmp = 0;
   int n_err = 0;

   ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .flush(a_flush),
      .in_valid(a_iv), .in_ready(a_ir),
      .in_reg_write(a_rw), .in_mem_to_reg(a_m2r), .in_mem_write(a_mw), .in_zero(a_zero),
      .in_alu_out(a_alu), .in_write_data(a_wd), .in_write_reg(a_wreg),
      .out_valid(a_ov), .out_ready(a_ordy),
      .out_reg_write(a_orw), .out_mem_to_reg(a_om2r), .out_mem_write(a_omw), .out_zero(a_ozero),
      .out_alu_out(a_oalu), .out_write_data(a_owd), .out_write_reg(a_owreg),
      .occupancy(a_occ)
   );

   ex_mem_pipe_reg #(.DATA_W(64), .REG_ADDR_W(5), .SKID(0)) u_dut64 (
      .clock(clock), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_iv), .in_ready(b_ir),
      .in_reg_write(b_rw), .in_mem_to_reg(b_m2r), .in_mem_write(b_mw), .in_zero(b_zero),
      .in_alu_out(b_alu), .in_write_data(b_wd), .in_write_reg(b_wreg),
      .out_valid(b_ov), .out_ready(b_ordy),
      .out_reg_write(b_orw), .out_mem_to_reg(b_om2r), .out_mem_write(b_omw), .out_zero(b_ozero),
      .out_alu_out(b_oalu), .out_write_data(b_owd), .out_write_reg(b_owreg),
      .occupancy(b_occ)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        flush, iv, rw, mw;
      logic [31:0] alu;
      logic        ordy;
      logic        e_ov, e_ir;
      logic [1:0]  e_occ;
      logic        e_rw, e_mw, chk;
      logic [31:0] e_alu;
   } vec_t;

   function automatic vec_t v(input logic f, input logic iv, input logic rw, input logic mw,
                              input logic [31:0] alu, input logic ordy,
                              input logic eov, input logic eir, input logic [1:0] eocc,
                              input logic erw, input logic emw, input logic chk,
                              input logic [31:0] ealu);
      vec_t r;
      r.flush = f; r.iv = iv; r.rw = rw; r.mw = mw; r.alu = alu; r.ordy = ordy;
      r.e_ov = eov; r.e_ir = eir; r.e_occ = eocc; r.e_rw = erw; r.e_mw = emw;
      r.chk = chk; r.e_alu = ealu;
      return r;
   endfunction

   // Side fields of DUT A are fixed functions of alu_out.
   task automatic drive_a(input logic f, input logic iv, input logic rw, input logic mw,
                          input logic [31:0] alu, input logic ordy);
      a_flush = f; a_iv = iv; a_rw = rw; a_mw = mw; a_alu = alu; a_ordy = ordy;
      a_wd    = alu ^ 32'hA5A5_0000;
      a_wreg  = alu[4:0] ^ 5'h1F;
      a_m2r   = alu[4];
      a_zero  = alu[5];
   endtask

   vec_t vecs[$];

   initial begin
      logic [63:0] val, last;

      reset_n = 1'b0;
      drive_a(0, 0, 0, 0, 32'h0, 0);
      b_flush = 0; b_iv = 0; b_rw = 0; b_m2r = 0; b_mw = 0; b_zero = 0;
      b_alu = '0; b_wd = '0; b_wreg = '0; b_ordy = 0;

      // stream
      vecs.push_back(v(0,1,1,0,32'h10,1, 1,1,1,1,0,1,32'h10));
      vecs.push_back(v(0,1,1,0,32'h20,1, 1,1,1,1,0,1,32'h20));
      vecs.push_back(v(0,1,1,0,32'h30,1, 1,1,1,1,0,1,32'h30));
      vecs.push_back(v(0,1,1,0,32'h40,1, 1,1,1,1,0,1,32'h40));
      vecs.push_back(v(0,0,0,0,32'h0 ,1, 0,1,0,0,0,0,32'h0));
      // stall into skid, third word held upstream, release in order
      vecs.push_back(v(0,1,0,1,32'h0A,0, 1,1,1,0,1,1,32'h0A));
      vecs.push_back(v(0,1,1,0,32'h0B,0, 1,0,2,0,1,1,32'h0A));
      vecs.push_back(v(0,1,1,1,32'h0C,0, 1,0,2,0,1,1,32'h0A));
      vecs.push_back(v(0,1,1,1,32'h0C,1, 1,1,1,1,0,1,32'h0B));
      vecs.push_back(v(0,1,1,1,32'h0C,1, 1,1,1,1,1,1,32'h0C));
      vecs.push_back(v(0,0,0,0,32'h0 ,1, 0,1,0,0,0,0,32'h0));
      // flush while FULL with a valid input
      vecs.push_back(v(0,1,1,1,32'h0E,0, 1,1,1,1,1,1,32'h0E));
      vecs.push_back(v(0,1,0,0,32'h0F,0, 1,0,2,1,1,1,32'h0E));
      vecs.push_back(v(1,1,1,1,32'h0D,0, 0,1,0,0,0,0,32'h0));
      vecs.push_back(v(0,0,0,0,32'h0 ,1, 0,1,0,0,0,0,32'h0));
      // bubble with write controls asserted
      vecs.push_back(v(0,0,1,1,32'h77,0, 0,1,0,0,0,0,32'h0));
      // flush together with out_ready
      vecs.push_back(v(0,1,1,1,32'h11,0, 1,1,1,1,1,1,32'h11));
      vecs.push_back(v(1,1,1,1,32'h12,1, 0,1,0,0,0,0,32'h0));
      vecs.push_back(v(0,0,0,0,32'h0 ,0, 0,1,0,0,0,0,32'h0));
      // skid entry moves to main on drain
      vecs.push_back(v(0,1,1,0,32'h21,0, 1,1,1,1,0,1,32'h21));
      vecs.push_back(v(0,1,0,1,32'h22,0, 1,0,2,1,0,1,32'h21));
      vecs.push_back(v(0,0,0,0,32'h0 ,1, 1,1,1,0,1,1,32'h22));
      vecs.push_back(v(0,0,0,0,32'h0 ,1, 0,1,0,0,0,0,32'h0));

      repeat (2) @(posedge clock);
      #1;
      check("rst.a_ov",  64'(a_ov),   64'h0);
      check("rst.a_ir",  64'(a_ir),   64'h1);
      check("rst.a_occ", 64'(a_occ),  64'h0);
      check("rst.a_alu", 64'(a_oalu), 64'h0);
      check("rst.a_rw",  64'(a_orw),  64'h0);
      check("rst.b_ov",  64'(b_ov),   64'h0);
      check("rst.b_ir",  64'(b_ir),   64'h1);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         drive_a(vecs[i].flush, vecs[i].iv, vecs[i].rw, vecs[i].mw, vecs[i].alu, vecs[i].ordy);
         @(posedge clock);
         #1;
         check($sformatf("v%0d.ov",  i), 64'(a_ov),  64'(vecs[i].e_ov));
         check($sformatf("v%0d.ir",  i), 64'(a_ir),  64'(vecs[i].e_ir));
         check($sformatf("v%0d.occ", i), 64'(a_occ), 64'(vecs[i].e_occ));
         check($sformatf("v%0d.rw",  i), 64'(a_orw), 64'(vecs[i].e_rw));
         check($sformatf("v%0d.mw",  i), 64'(a_omw), 64'(vecs[i].e_mw));
         if (vecs[i].chk) begin
            check($sformatf("v%0d.alu",  i), 64'(a_oalu),  64'(vecs[i].e_alu));
            check($sformatf("v%0d.wd",   i), 64'(a_owd),   64'(vecs[i].e_alu ^ 32'hA5A5_0000));
            check($sformatf("v%0d.wreg", i), 64'(a_owreg), 64'(vecs[i].e_alu[4:0] ^ 5'h1F));
            check($sformatf("v%0d.m2r",  i), 64'(a_om2r),  64'(vecs[i].e_alu[4]));
            check($sformatf("v%0d.zero", i), 64'(a_ozero), 64'(vecs[i].e_alu[5]));
         end
      end
      drive_a(0, 0, 0, 0, 32'h0, 0);

      // SKID=0, 64-bit: accept while draining every cycle
      last = '0;
      for (int i = 0; i < 5; i++) begin
         val    = 64'hDEAD_BEEF_0123_4567 + 64'(i) * 64'h1111_0000_1111_0001;
         b_iv   = 1; b_ordy = 1; b_rw = 1; b_mw = i[0];
         b_alu  = val; b_wd = ~val; b_wreg = val[4:0];
         #1;
         check($sformatf("b%0d.ir_pre", i), 64'(b_ir), 64'h1);
         @(posedge clock);
         #1;
         check($sformatf("b%0d.ov",   i), 64'(b_ov),    64'h1);
         check($sformatf("b%0d.alu",  i), b_oalu,       val);
         check($sformatf("b%0d.wd",   i), b_owd,        ~val);
         check($sformatf("b%0d.wreg", i), 64'(b_owreg), 64'(val[4:0]));
         check($sformatf("b%0d.mw",   i), 64'(b_omw),   64'(i[0]));
         check($sformatf("b%0d.occ",  i), 64'(b_occ),   64'h1);
         last = val;
      end
      // SKID=0 stall: input ignored while full and not draining
      b_ordy = 0; b_alu = 64'h0BAD_0BAD_0BAD_0BAD; b_wd = '0;
      #1;
      check("b.stall.ir", 64'(b_ir), 64'h0);
      @(posedge clock);
      #1;
      check("b.stall.alu", b_oalu,      last);
      check("b.stall.occ", 64'(b_occ),  64'h1);
      b_iv = 0; b_ordy = 1;
      @(posedge clock);
      #1;
      check("b.drain.ov", 64'(b_ov),  64'h0);
      check("b.drain.rw", 64'(b_orw), 64'h0);
      check("b.drain.ir", 64'(b_ir),  64'h1);

      // Reset mid-stream: both stages hold data, reset asserted between edges
      drive_a(0, 1, 1, 1, 32'h31, 0);
      b_iv = 1; b_ordy = 0; b_alu = 64'h1234_5678_9ABC_DEF0;
      @(posedge clock);
      #1;
      drive_a(0, 1, 1, 1, 32'h32, 0);
      b_iv = 0;
      @(posedge clock);
      #1;
      check("pre.a_occ", 64'(a_occ), 64'h2);
      check("pre.b_ov",  64'(b_ov),  64'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst.a_ov",  64'(a_ov),   64'h0);
      check("arst.a_alu", 64'(a_oalu), 64'h0);
      check("arst.a_occ", 64'(a_occ),  64'h0);
      check("arst.a_ir",  64'(a_ir),   64'h1);
      check("arst.b_ov",  64'(b_ov),   64'h0);
      check("arst.b_alu", b_oalu,      64'h0);
      drive_a(0, 0, 0, 0, 32'h0, 1);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("post.a_ov", 64'(a_ov), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
